// File: rtl/datapath.sv
// Register/bus/ALU/RAM half of the 8-bit machine: shared bus, A/B/OUT/IR/MAR/PC, 16x8 RAM, flags.
// Option: define DATAPATH_RAM_CLEAR_EN to have RESET also clear all RAM words.
module datapath (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLR,
  input  logic       HLT,
  input  logic       CE,
  input  logic       SU,
  input  logic       RI,
  input  logic       AIn,
  input  logic       BIn,
  input  logic       OIn,
  input  logic       IIn,
  input  logic       Jn,
  input  logic       FIn,
  input  logic       MIn,
  input  logic       AOn,
  input  logic       BOn,
  input  logic       IOn,
  input  logic       COn,
  input  logic       EOn,
  input  logic       ROn,
  input  logic       NOn,
  input  logic [7:0] IN_DATA,
  input  logic       PROG_WE,
  input  logic [3:0] PROG_ADDR,
  input  logic [7:0] PROG_DATA,
  output logic [3:0] OPCODE,
  output logic       CF,
  output logic       ZF,
  output logic [7:0] OUT_DATA,
  output logic       OUT_STB,
  output logic [7:0] BUS
);

  logic [7:0] r_a, r_b, r_out, r_ir;
  logic [3:0] r_mar, r_pc;
  logic       r_cf, r_zf, r_out_stb;
  logic [7:0] r_ram [16];

  logic [8:0] w_alu;
  logic [7:0] w_bus;
  logic       w_ri_we;
  logic       w_ram_we [16];
  logic [7:0] w_ram_wd [16];

  always_comb begin
    w_alu = {1'b0, r_a} + {1'b0, (SU ? ~r_b : r_b)} + {8'd0, SU};
  end

  always_comb begin
    w_bus = '0;
    if      (!ROn) w_bus = r_ram[r_mar];
    else if (!EOn) w_bus = w_alu[7:0];
    else if (!AOn) w_bus = r_a;
    else if (!BOn) w_bus = r_b;
    else if (!IOn) w_bus = {4'h0, r_ir[3:0]};
    else if (!COn) w_bus = {4'h0, r_pc};
    else if (!NOn) w_bus = IN_DATA;
  end

  // Port write wins only on an address collision; otherwise both writes land.
  always_comb begin
    w_ri_we = RI && !HLT && !CLR;
    for (int unsigned i = 0; i < 16; i++) begin
      w_ram_we[i] = 1'b0;
      w_ram_wd[i] = '0;
      if (PROG_WE && (PROG_ADDR == 4'(i))) begin
        w_ram_we[i] = 1'b1;
        w_ram_wd[i] = PROG_DATA;
      end else if (w_ri_we && (r_mar == 4'(i))) begin
        w_ram_we[i] = 1'b1;
        w_ram_wd[i] = w_bus;
      end
    end
  end

`ifdef DATAPATH_RAM_CLEAR_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 16; i++) r_ram[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++)
        if (w_ram_we[i]) r_ram[i] <= w_ram_wd[i];
    end
  end
`else
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < 16; i++)
      if (w_ram_we[i]) r_ram[i] <= w_ram_wd[i];
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_a <= '0; r_b <= '0; r_out <= '0; r_ir <= '0;
      r_mar <= '0; r_pc <= '0; r_cf <= 1'b0; r_zf <= 1'b0;
      r_out_stb <= 1'b0;
    end else if (CLR) begin
      r_a <= '0; r_b <= '0; r_out <= '0; r_ir <= '0;
      r_mar <= '0; r_pc <= '0; r_cf <= 1'b0; r_zf <= 1'b0;
      r_out_stb <= 1'b0;
    end else begin
      r_out_stb <= !HLT && !OIn;
      if (!HLT) begin
        if (!AIn) r_a   <= w_bus;
        if (!BIn) r_b   <= w_bus;
        if (!OIn) r_out <= w_bus;
        if (!IIn) r_ir  <= w_bus;
        if (!MIn) r_mar <= w_bus[3:0];
        if (!FIn) begin
          r_cf <= w_alu[8];
          r_zf <= (w_alu[7:0] == 8'h00);
        end
        if (!Jn)     r_pc <= w_bus[3:0];
        else if (CE) r_pc <= r_pc + 4'd1;
      end
    end
  end

  assign OPCODE   = r_ir[7:4];
  assign CF       = r_cf;
  assign ZF       = r_zf;
  assign OUT_DATA = r_out;
  assign OUT_STB  = r_out_stb;
  assign BUS      = w_bus;

endmodule

// File: tb/tb_datapath.sv
// Directed vector bench for datapath: table of single-cycle strobe vectors plus hand sequences.
module tb_datapath;

  logic       CLK, RESET, CLR, HLT, CE, SU, RI;
  logic       AIn, BIn, OIn, IIn, Jn, FIn, MIn;
  logic       AOn, BOn, IOn, COn, EOn, ROn, NOn;
  logic [7:0] IN_DATA, PROG_DATA;
  logic       PROG_WE;
  logic [3:0] PROG_ADDR;
  logic [3:0] OPCODE;
  logic       CF, ZF, OUT_STB;
  logic [7:0] OUT_DATA, BUS;

  datapath dut (
    .CLK(CLK), .RESET(RESET), .CLR(CLR), .HLT(HLT), .CE(CE), .SU(SU), .RI(RI),
    .AIn(AIn), .BIn(BIn), .OIn(OIn), .IIn(IIn), .Jn(Jn), .FIn(FIn), .MIn(MIn),
    .AOn(AOn), .BOn(BOn), .IOn(IOn), .COn(COn), .EOn(EOn), .ROn(ROn), .NOn(NOn),
    .IN_DATA(IN_DATA), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
    .OPCODE(OPCODE), .CF(CF), .ZF(ZF), .OUT_DATA(OUT_DATA), .OUT_STB(OUT_STB), .BUS(BUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int unsigned C_CLR = 1 << 0,  C_HLT = 1 << 1,  C_CE = 1 << 2,  C_SU = 1 << 3;
  localparam int unsigned C_RI  = 1 << 4,  C_AI  = 1 << 5,  C_BI = 1 << 6,  C_OI = 1 << 7;
  localparam int unsigned C_II  = 1 << 8,  C_J   = 1 << 9,  C_FI = 1 << 10, C_MI = 1 << 11;
  localparam int unsigned C_AO  = 1 << 12, C_BO  = 1 << 13, C_IO = 1 << 14, C_CO = 1 << 15;
  localparam int unsigned C_EO  = 1 << 16, C_RO  = 1 << 17, C_NO = 1 << 18;

  typedef struct {
    string      name;
    int unsigned ctl;
    logic [7:0] din;
    logic [7:0] bus;
    logic       cf;
    logic       zf;
    logic [7:0] out;
    logic       stb;
    logic [3:0] op;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int unsigned c, input logic [7:0] d);
    CLR = (c & C_CLR) != 0;  HLT = (c & C_HLT) != 0;
    CE  = (c & C_CE) != 0;   SU  = (c & C_SU) != 0;  RI = (c & C_RI) != 0;
    AIn = (c & C_AI) == 0;   BIn = (c & C_BI) == 0;  OIn = (c & C_OI) == 0;
    IIn = (c & C_II) == 0;   Jn  = (c & C_J) == 0;   FIn = (c & C_FI) == 0;
    MIn = (c & C_MI) == 0;   AOn = (c & C_AO) == 0;  BOn = (c & C_BO) == 0;
    IOn = (c & C_IO) == 0;   COn = (c & C_CO) == 0;  EOn = (c & C_EO) == 0;
    ROn = (c & C_RO) == 0;   NOn = (c & C_NO) == 0;
    IN_DATA = d;
  endtask

  // Strobes change on the falling edge, bus checked before the rising edge.
  task automatic cyc(input int unsigned c, input logic [7:0] d, input string nm,
                     input logic [7:0] exp_bus);
    @(negedge CLK);
    drive(c, d);
    #1 chk({nm, ".bus"}, BUS, exp_bus);
    @(posedge CLK);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    PROG_WE = 1'b1; PROG_ADDR = a; PROG_DATA = d;
    @(posedge CLK);
    #1 PROG_WE = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"ir_load",   C_NO | C_II,        8'h1E, 8'h1E, 0, 0, 8'h00, 0, 4'h1};
    vecs[1]  = '{"mar_ir",    C_IO | C_MI,        8'h00, 8'h0E, 0, 0, 8'h00, 0, 4'h1};
    vecs[2]  = '{"a_ram14",   C_RO | C_AI,        8'h00, 8'h1C, 0, 0, 8'h00, 0, 4'h1};
    vecs[3]  = '{"mar15",     C_NO | C_MI,        8'h0F, 8'h0F, 0, 0, 8'h00, 0, 4'h1};
    vecs[4]  = '{"b_ram15",   C_RO | C_BI,        8'h00, 8'h0E, 0, 0, 8'h00, 0, 4'h1};
    vecs[5]  = '{"add_fi",    C_EO | C_AI | C_FI, 8'h00, 8'h2A, 0, 0, 8'h00, 0, 4'h1};
    vecs[6]  = '{"a_2a",      C_AO,               8'h00, 8'h2A, 0, 0, 8'h00, 0, 4'h1};
    vecs[7]  = '{"a_05",      C_NO | C_AI,        8'h05, 8'h05, 0, 0, 8'h00, 0, 4'h1};
    vecs[8]  = '{"b_05",      C_NO | C_BI,        8'h05, 8'h05, 0, 0, 8'h00, 0, 4'h1};
    vecs[9]  = '{"sub_eq",    C_EO | C_FI | C_SU, 8'h00, 8'h00, 1, 1, 8'h00, 0, 4'h1};
    vecs[10] = '{"a_03",      C_NO | C_AI,        8'h03, 8'h03, 1, 1, 8'h00, 0, 4'h1};
    vecs[11] = '{"sub_neg",   C_EO | C_FI | C_SU, 8'h00, 8'hFE, 0, 0, 8'h00, 0, 4'h1};
    vecs[12] = '{"a_ff",      C_NO | C_AI,        8'hFF, 8'hFF, 0, 0, 8'h00, 0, 4'h1};
    vecs[13] = '{"add_carry", C_EO | C_FI,        8'h00, 8'h04, 1, 0, 8'h00, 0, 4'h1};
    vecs[14] = '{"jmp_f",     C_NO | C_J,         8'h0F, 8'h0F, 1, 0, 8'h00, 0, 4'h1};
    vecs[15] = '{"pc_wrap",   C_CO | C_CE,        8'h00, 8'h0F, 1, 0, 8'h00, 0, 4'h1};
    vecs[16] = '{"pc_0",      C_CO,               8'h00, 8'h00, 1, 0, 8'h00, 0, 4'h1};
    vecs[17] = '{"jmp_ce",    C_NO | C_J | C_CE,  8'h37, 8'h37, 1, 0, 8'h00, 0, 4'h1};
    vecs[18] = '{"pc_7",      C_CO,               8'h00, 8'h07, 1, 0, 8'h00, 0, 4'h1};
    vecs[19] = '{"a_99",      C_NO | C_AI,        8'h99, 8'h99, 1, 0, 8'h00, 0, 4'h1};
    vecs[20] = '{"out_99",    C_AO | C_OI,        8'h00, 8'h99, 1, 0, 8'h99, 1, 4'h1};
    vecs[21] = '{"stb_drop",  0,                  8'h00, 8'h00, 1, 0, 8'h99, 0, 4'h1};
    vecs[22] = '{"out_rep1",  C_AO | C_OI,        8'h00, 8'h99, 1, 0, 8'h99, 1, 4'h1};
    vecs[23] = '{"out_rep2",  C_AO | C_OI,        8'h00, 8'h99, 1, 0, 8'h99, 1, 4'h1};
    vecs[24] = '{"stb_drop2", 0,                  8'h00, 8'h00, 1, 0, 8'h99, 0, 4'h1};
    vecs[25] = '{"ab_40",     C_NO | C_AI | C_BI, 8'h40, 8'h40, 1, 0, 8'h99, 0, 4'h1};
    vecs[26] = '{"add_80",    C_EO,               8'h00, 8'h80, 1, 0, 8'h99, 0, 4'h1};

    RESET = 1'b1; PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0;
    drive(0, 8'h00);
    #12;
    chk("rst.bus", BUS, 8'h00);
    chk("rst.op", {4'h0, OPCODE}, 8'h00);
    chk("rst.out", OUT_DATA, 8'h00);
    chk("rst.flags", {6'd0, CF, ZF}, 8'h00);
    chk("rst.stb", {7'd0, OUT_STB}, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    prog(4'd14, 8'h1C);
    prog(4'd15, 8'h0E);
    prog(4'd0,  8'h5A);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].ctl, vecs[i].din, vecs[i].name, vecs[i].bus);
      chk({vecs[i].name, ".cf"},  {7'd0, CF}, {7'd0, vecs[i].cf});
      chk({vecs[i].name, ".zf"},  {7'd0, ZF}, {7'd0, vecs[i].zf});
      chk({vecs[i].name, ".out"}, OUT_DATA, vecs[i].out);
      chk({vecs[i].name, ".stb"}, {7'd0, OUT_STB}, {7'd0, vecs[i].stb});
      chk({vecs[i].name, ".op"},  {4'h0, OPCODE}, {4'h0, vecs[i].op});
    end

    // Halt: A=40 B=40 PC=7 MAR=F OUT=99; only the programming port may write.
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        PROG_WE = 1'b1; PROG_ADDR = 4'd3; PROG_DATA = 8'h33;
      end
      cyc(C_HLT | C_AI | C_OI | C_CE | C_RI | C_NO | C_FI | C_J, 8'h77, "hlt", 8'h77);
      PROG_WE = 1'b0;
      chk("hlt.stb", {7'd0, OUT_STB}, 8'h00);
      chk("hlt.out", OUT_DATA, 8'h99);
      chk("hlt.cf", {7'd0, CF}, 8'h01);
    end
    cyc(C_AO, 8'h00, "hlt_a", 8'h40);
    cyc(C_CO, 8'h00, "hlt_pc", 8'h07);
    cyc(C_RO, 8'h00, "hlt_ram15", 8'h0E);
    cyc(C_NO | C_MI, 8'h03, "mar3", 8'h03);
    cyc(C_RO, 8'h00, "hlt_prog", 8'h33);

    // Port write vs RI at the same and at different addresses.
    PROG_WE = 1'b1; PROG_ADDR = 4'd3; PROG_DATA = 8'h66;
    cyc(C_RI | C_NO, 8'h55, "ri_clash", 8'h55);
    PROG_WE = 1'b0;
    cyc(C_RO, 8'h00, "clash_rd", 8'h66);
    PROG_WE = 1'b1; PROG_ADDR = 4'd4; PROG_DATA = 8'h44;
    cyc(C_RI | C_NO, 8'h55, "ri_both", 8'h55);
    PROG_WE = 1'b0;
    cyc(C_RO, 8'h00, "both_ri", 8'h55);
    cyc(C_NO | C_MI, 8'h04, "mar4", 8'h04);
    cyc(C_RO, 8'h00, "both_prog", 8'h44);

    // CLR works even while halted and leaves RAM alone.
    cyc(C_CLR | C_HLT | C_NO, 8'h12, "clr", 8'h12);
    chk("clr.out", OUT_DATA, 8'h00);
    chk("clr.flags", {6'd0, CF, ZF}, 8'h00);
    chk("clr.op", {4'h0, OPCODE}, 8'h00);
    chk("clr.stb", {7'd0, OUT_STB}, 8'h00);
    cyc(C_AO, 8'h00, "clr_a", 8'h00);
    cyc(C_BO, 8'h00, "clr_b", 8'h00);
    cyc(C_CO, 8'h00, "clr_pc", 8'h00);
    cyc(C_RO, 8'h00, "clr_ram0", 8'h5A);

    // Build up state, then reset asynchronously mid-cycle.
    cyc(C_NO | C_AI, 8'hAA, "a_aa", 8'hAA);
    cyc(C_NO | C_J, 8'h09, "pc_9", 8'h09);
    cyc(C_NO | C_II, 8'hF3, "ir_f3", 8'hF3);
    cyc(C_EO | C_FI | C_SU, 8'h00, "sub_aa", 8'hAA);
    chk("sub_aa.cf", {7'd0, CF}, 8'h01);
    cyc(C_AO | C_OI, 8'h00, "out_aa", 8'hAA);
    chk("out_aa.stb", {7'd0, OUT_STB}, 8'h01);
    chk("out_aa.op", {4'h0, OPCODE}, 8'h0F);
    @(negedge CLK);
    drive(C_AO, 8'h00);
    #2 RESET = 1'b1;
    #1;
    chk("arst.bus", BUS, 8'h00);
    chk("arst.out", OUT_DATA, 8'h00);
    chk("arst.stb", {7'd0, OUT_STB}, 8'h00);
    chk("arst.op", {4'h0, OPCODE}, 8'h00);
    chk("arst.cf", {7'd0, CF}, 8'h00);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    cyc(C_CO, 8'h00, "arst_pc", 8'h00);
    cyc(C_IO, 8'h00, "arst_ir", 8'h00);
`ifdef DATAPATH_RAM_CLEAR_EN
    cyc(C_RO, 8'h00, "arst_ram0", 8'h00);
`else
    cyc(C_RO, 8'h00, "arst_ram0", 8'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
